serial_addsub: RTL and testbench

- Parametrised, bit-serial successor to the single-bit full adder: one full-adder cell plus a carry flip-flop adds or subtracts two WIDTH-bit operands, LSB first, one bit per clock.
- Trades WIDTH cycles of latency for a single adder cell.
- Has a start/busy/done handshake, an add/subtract mode, and carry-out and signed-overflow flags.
- Feeds the lab ALU datapath where area matters more than latency.

---
 rtl/serial_addsub.sv | 108 ++++++++++
 tb/tb_serial_addsub.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// two WIDTH-bit operands LSB first, one bit per clock, with start/busy/done.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res_sr;
  logic             r_carry;
  logic             r_c_msb;
  logic [CNT_W-1:0] r_count;

  logic             w_sum;
  logic             w_carry_nxt;
  logic             w_last;
  logic             w_pre_msb;
  logic [WIDTH-1:0] w_res_nxt;

  // Single full-adder cell on the current LSBs
  assign w_sum       = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_carry_nxt = (r_a_sr[0] & r_b_sr[0]) |
                       (r_a_sr[0] & r_carry)   |
                       (r_b_sr[0] & r_carry);
  assign w_last      = (r_count == CNT_W'(WIDTH - 1));
  assign w_pre_msb   = (r_count == CNT_W'(WIDTH - 2));
  assign w_res_nxt   = {w_sum, r_res_sr};

  // Control FSM and datapath registers; outputs load only on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_carry  <= 1'b0;
      r_c_msb  <= 1'b0;
      r_count  <= '0;
      S        <= '0;
      Cout     <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so Cin is replaced by a forced 1
            r_a_sr  <= a;
            r_b_sr  <= mode ? ~b : b;
            r_carry <= mode ? 1'b1 : Cin;
            r_count <= '0;
            busy    <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_nxt[WIDTH-1:1];
          r_carry  <= w_carry_nxt;
          r_count  <= r_count + CNT_W'(1);
          if (w_pre_msb) begin
            r_c_msb <= w_carry_nxt;
          end
          if (w_last) begin
            S       <= w_res_nxt;
            Cout    <= w_carry_nxt;
            ovf     <= r_c_msb ^ w_carry_nxt;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8 vectors plus a WIDTH=4 sweep.
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;

  logic       start8, mode8, cin8;
  logic [7:0] a8, b8, s8;
  logic       cout8, ovf8, busy8, done8;

  logic       start4, mode4, cin4;
  logic [3:0] a4, b4, s4;
  logic       cout4, ovf4, busy4, done4;

  int n_checks = 0;
  int n_errors = 0;

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
    .a(a8), .b(b8), .Cin(cin8),
    .S(s8), .Cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4),
    .a(a4), .b(b4), .Cin(cin4),
    .S(s4), .Cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy-high samples after the accept edge; returns with done expected high
  task automatic wait_done8(output int n);
    n = 0;
    while (busy8 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic tc, input logic tm,
                     input logic [7:0] es, input logic ec, input logic ev);
    int n;
    a8 = ta; b8 = tb; cin8 = tc; mode8 = tm; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = ~ta; b8 = ~tb; cin8 = ~tc; mode8 = ~tm;
    wait_done8(n);
    check({tag, "_busycyc"}, 32'(n), 32'd8);
    check({tag, "_done"}, 32'(done8), 32'd1);
    check({tag, "_S"}, 32'(s8), 32'(es));
    check({tag, "_Cout"}, 32'(cout8), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf8), 32'(ev));
    tick();
    check({tag, "_done_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] bb, es;
    logic [4:0] sum5;
    logic       cc, ev;

    rst_n = 1'b0;
    start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; mode4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    #1;
    check("rst_S", 32'(s8), 32'd0);
    check("rst_flags", 32'({cout8, ovf8, busy8, done8}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of an operation
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_S", 32'(s8), 32'd0);
    check("midrst_flags", 32'({cout8, ovf8, busy8, done8}), 32'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) n++;
    end
    check("midrst_no_done", 32'(n), 32'd0);

    op8("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8("sub_brw",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);

    // Back-to-back: start held high through the done cycle
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; mode8 = 1'b1; start8 = 1'b1;
    tick();
    wait_done8(n);
    check("b2b1_busycyc", 32'(n), 32'd8);
    check("b2b1_done", 32'(done8), 32'd1);
    check("b2b1_S", 32'(s8), 32'h7F);
    check("b2b1_CV", 32'({cout8, ovf8}), 32'b11);
    a8 = 8'h10; b8 = 8'h03; mode8 = 1'b0;
    tick();
    start8 = 1'b0;
    check("b2b2_restart", 32'({busy8, done8}), 32'b10);
    check("b2b2_hold_S", 32'(s8), 32'h7F);
    wait_done8(n);
    check("b2b2_busycyc", 32'(n), 32'd8);
    check("b2b2_S", 32'(s8), 32'h13);
    check("b2b2_CV", 32'({cout8, ovf8}), 32'b00);
    tick();

    // WIDTH=4: start pulsed mid-operation with new operands is ignored
    a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0; mode4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a4 = 4'hF; b4 = 4'hF; mode4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 2;
    while (busy4 && n < 20) begin
      n++;
      tick();
    end
    check("ign_busycyc", 32'(n), 32'd4);
    check("ign_S", 32'(s4), 32'h8);
    check("ign_CV", 32'({cout4, ovf4, done4}), 32'b011);
    tick();

    // WIDTH=4 exhaustive sweep against a word-level model
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 2; c++) begin
        for (int ia = 0; ia < 16; ia++) begin
          for (int ib = 0; ib < 16; ib++) begin
            bb   = (m != 0) ? ~4'(ib) : 4'(ib);
            cc   = (m != 0) ? 1'b1 : 1'(c);
            sum5 = 5'(ia) + 5'(bb) + 5'(cc);
            es   = sum5[3:0];
            ev   = (4'(ia) >> 3 == bb >> 3) && (es[3] != 1'(ia >> 3));
            a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(c); mode4 = 1'(m); start4 = 1'b1;
            tick();
            start4 = 1'b0;
            n = 0;
            while (busy4 && n < 20) begin
              n++;
              tick();
            end
            check("sw_busycyc", 32'(n), 32'd4);
            check("sw_S", 32'(s4), 32'(es));
            check("sw_CVD", 32'({cout4, ovf4, done4}), 32'({sum5[4], ev, 1'b1}));
            tick();
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
